inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Instruction fetch sequencer. Feeds the instruction decoder: it reads two 64-bit memory words at
//  PC and PC+8, presents them as opf8/opl8 with a one-instruction exec window, then advances PC or
//  takes the decoder's jump. Sits between the memory read port and the control decoder.
// PARAMETERS
//  RESET_VEC   64'h0  PC loaded on reset
//  INSN_BYTES  12     bytes per instruction; sequential PC increment (opf8 + opl8[31:0])
// PORTS
//  clk         in   1   clock, rising edge
//  rst_n       in   1   asynchronous reset, active low
//  mem_req     out  1   read request; held until mem_ack
//  mem_addr    out  64  byte address of the read; stable while mem_req=1
//  mem_rdata   in   64  read data, valid when mem_ack=1
//  mem_ack     in   1   read complete; sampled only while mem_req=1; may be high in the same cycle as req
//  opf8        out  64  first instruction word (bytes PC..PC+7) to the decoder
//  opl8        out  64  second instruction word (bytes PC+8..PC+15) to the decoder
//  exec        out  1   instruction valid; the decoder gates all side effects with it
//  pc          out  64  address of the instruction in opf8/opl8; used for link/return
//  hold        in   1   datapath stall; freezes the EX state
//  jump        in   1   decoder jump (already qualified with exec), sampled in EX only
//  jump_target in   64  target PC when jump=1
// BEHAVIOUR
//  Reset (async, rst_n=0): state=F_LO, pc=RESET_VEC, opf8=opl8=0, exec=0, mem_req=0. First req one
//   cycle after rst_n deasserts. Reset mid-transaction abandons it; a late mem_ack is ignored.
//  FSM: F_LO -> F_HI -> EX -> F_LO.
//   F_LO: mem_req=1, mem_addr=pc; on mem_ack: opf8<=mem_rdata, go F_HI.
//   F_HI: mem_req=1, mem_addr=pc+8; on mem_ack: opl8<=mem_rdata, go EX.
//   EX:   exec=1, mem_req=0. If hold=1, stay in EX: exec, opf8, opl8 and pc stay stable, and jump is
//         ignored. If hold=0, leave for F_LO:
//         pc <= jump ? jump_target : pc + INSN_BYTES.
//  exec is registered: it is high exactly while state==EX. Minimum cycle count per instruction is
//   3 (ack in the same cycle as req); each wait cycle on mem_ack adds one.
//  mem_req and mem_addr are driven from state and pc only (no combinational path from mem_ack).
//  Arithmetic is mod 2^64: pc+8 and pc+INSN_BYTES wrap silently. jump_target is not aligned or checked.
//  jump outside EX is ignored. mem_rdata outside an acked req cycle is ignored.
//  opf8 and opl8 are updated only on acked reads. They keep the previous instruction during F_LO/F_HI.
// STRUCTURE
//  t64_pkg: typedef enum logic[1:0] {F_LO, F_HI, EX} fetch_state_t; localparam T64_WORD_BYTES=8.
//  Single module: one state register, pc/opf8/opl8 registers, combinational next-state/output.
//  No sub-module.
// TESTING
//  1 Reset: RESET_VEC=64'h1000, rst_n low 3 cycles then high -> next cycle mem_req=1,
//    mem_addr=64'h1000, exec=0.
//  2 Zero-wait fetch: ack same cycle, data A@0x1000, B@0x1008 -> exec=1 in 3rd cycle, opf8=A,
//    opl8=B, pc=0x1000; next req mem_addr=0x100C.
//  3 Jump: in EX, jump=1, jump_target=0x2000, hold=0 -> next mem_addr=0x2000, pc=0x2000.
//    jump=1 pulsed during F_HI -> ignored, next addr pc+12.
//  4 Hold: hold=1 for 3 EX cycles with jump=1 only during hold, then hold=0/jump=0 -> exec high 4
//    cycles, outputs stable, no mem_req, next addr pc+12.
//  5 Wait states: mem_ack delayed 5 cycles in F_LO -> mem_req and mem_addr constant throughout,
//    opf8 unchanged until ack.
//  6 Async reset during F_HI, with mem_ack arriving the cycle after reset is released
//    -> outputs reset immediately (no clock); refetch at RESET_VEC; the late data is not captured.
//  7 Wrap: pc=64'hFFFF_FFFF_FFFF_FFFC -> F_HI addr=64'h4; next pc=64'h8.

Source files
------------

// File: rtl/t64_pkg.sv
// Shared types for the instruction fetch sequencer: fetch FSM states and the
// word-address helper used when presenting the second fetch beat.
package t64_pkg;

    typedef enum logic [1:0] {
        F_LO = 2'd0,
        F_HI = 2'd1,
        EX   = 2'd2
    } fetch_state_t;

    localparam logic [63:0] T64_WORD_BYTES = 64'd8;

    // Byte address requested in a given fetch state; the second beat sits one word above pc.
    function automatic logic [63:0] fetch_addr(input fetch_state_t st, input logic [63:0] pc);
        logic [63:0] addr;
        case (st)
            F_HI:    addr = pc + T64_WORD_BYTES;
            default: addr = pc;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch sequencer: reads the two words of the instruction at pc,
// presents them to the decoder for one exec window, then advances or jumps.
module inst_fetch
    import t64_pkg::*;
#(
    parameter logic [63:0] RESET_VEC  = 64'h0,
    parameter logic [63:0] INSN_BYTES = 64'd12
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack,
    output logic [63:0] opf8,
    output logic [63:0] opl8,
    output logic        exec,
    output logic [63:0] pc,
    input  logic        hold,
    input  logic        jump,
    input  logic [63:0] jump_target
);

    fetch_state_t state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [63:0]  opf8_q, opf8_d;
    logic [63:0]  opl8_q, opl8_d;
    logic [63:0]  mem_addr_q, mem_addr_d;
    logic         mem_req_q, mem_req_d;
    logic         exec_q, exec_d;
    logic         ack_s;

    // An ack only counts while a request is actually on the port; this also drops
    // a late ack from a transaction abandoned by reset.
    assign ack_s = mem_ack & mem_req_q;

    // Next-state and next-output logic; port outputs are precomputed from the next state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        opf8_d  = opf8_q;
        opl8_d  = opl8_q;
        case (state_q)
            F_LO: begin
                if (ack_s) begin
                    opf8_d  = mem_rdata;
                    state_d = F_HI;
                end else begin
                    state_d = F_LO;
                end
            end
            F_HI: begin
                if (ack_s) begin
                    opl8_d  = mem_rdata;
                    state_d = EX;
                end else begin
                    state_d = F_HI;
                end
            end
            EX: begin
                if (!hold) begin
                    state_d = F_LO;
                    pc_d    = jump ? jump_target : (pc_q + INSN_BYTES);
                end else begin
                    state_d = EX;
                end
            end
            default: begin
                state_d = F_LO;
            end
        endcase
        mem_req_d  = (state_d != EX);
        mem_addr_d = fetch_addr(state_d, pc_d);
        exec_d     = (state_d == EX);
    end

    // State, instruction and port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= F_LO;
            pc_q       <= RESET_VEC;
            opf8_q     <= 64'h0;
            opl8_q     <= 64'h0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_VEC;
            exec_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            opf8_q     <= opf8_d;
            opl8_q     <= opl8_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            exec_q     <= exec_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign opf8     = opf8_q;
    assign opl8     = opl8_q;
    assign exec     = exec_q;
    assign pc       = pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a memory responder with programmable wait
// states and a scoreboard of expected {pc, opf8, opl8} per executed instruction.
module tb_inst_fetch;

    localparam logic [63:0] RV = 64'h1000;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] opf8;
        logic [63:0] opl8;
    } insn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic [63:0] opf8;
    logic [63:0] opl8;
    logic        exec;
    logic [63:0] pc;
    logic        hold = 1'b0;
    logic        jump = 1'b0;
    logic [63:0] jump_target = 64'h0;

    int    checks = 0;
    int    failures = 0;
    int    wait_lo = 0;
    int    wait_hi = 0;
    int    wcnt = 0;
    bit    force_ack = 1'b0;
    insn_t sb_q[$];

    inst_fetch #(.RESET_VEC(RV), .INSN_BYTES(64'd12)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .opf8(opf8), .opl8(opl8),
        .exec(exec), .pc(pc), .hold(hold), .jump(jump), .jump_target(jump_target)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_model(input logic [63:0] a);
        return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    function automatic insn_t expect_insn(input logic [63:0] p);
        insn_t e;
        e.pc   = p;
        e.opf8 = mem_model(p);
        e.opl8 = mem_model(p + 64'd8);
        return e;
    endfunction

    // Memory responder: acts 1 time unit after each rising edge.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 64'h0;
        forever begin
            @(posedge clk);
            #1;
            if (force_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
                wcnt      = 0;
            end else if (!rst_n) begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end else if (mem_req && wcnt >= ((mem_addr == pc) ? wait_lo : wait_hi)) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_model(mem_addr);
                wcnt      = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
                if (mem_req) wcnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_exec(input int budget, output int cycles, output bit ok);
        cycles = 0;
        ok = 1'b0;
        while (cycles < budget) begin
            if (exec === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({mem_req, exec, pc, opf8, opl8} !== {1'b0, 1'b0, RV, 64'h0, 64'h0}) begin
            failures++;
            $display("FAIL reset_state: req=%b exec=%b pc=%h opf8=%h opl8=%h, expected 0 0 %h 0 0",
                     mem_req, exec, pc, opf8, opl8, RV);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({mem_req, mem_addr, exec} !== {1'b1, RV, 1'b0}) begin
            failures++;
            $display("FAIL reset_first_req: req=%b addr=%h exec=%b, expected 1 %h 0",
                     mem_req, mem_addr, exec, RV);
        end
    endtask

    task automatic test_zero_wait();
        int    n;
        bit    ok;
        insn_t e;
        sb_q.push_back(expect_insn(RV));
        wait_exec(20, n, ok);
        checks++;
        if (!ok || n != 2) begin
            failures++;
            $display("FAIL zero_wait_latency: ok=%0d cycles=%0d, expected exec after 2 more cycles", ok, n);
        end
        e = sb_q.pop_front();
        checks++;
        if ({pc, opf8, opl8} !== e) begin
            failures++;
            $display("FAIL zero_wait_insn: got %h/%h/%h expected %h/%h/%h", pc, opf8, opl8, e.pc, e.opf8, e.opl8);
        end
        step();
        checks++;
        if ({mem_req, mem_addr, exec} !== {1'b1, RV + 64'hC, 1'b0}) begin
            failures++;
            $display("FAIL zero_wait_next: req=%b addr=%h exec=%b, expected 1 %h 0", mem_req, mem_addr, exec, RV + 64'hC);
        end
    endtask

    task automatic test_jump();
        int    n;
        bit    ok;
        insn_t e;
        sb_q.push_back(expect_insn(RV + 64'hC));
        wait_exec(20, n, ok);
        e = sb_q.pop_front();
        checks++;
        if (!ok || {pc, opf8, opl8} !== e) begin
            failures++;
            $display("FAIL jump_pre_insn: ok=%0d got %h/%h/%h expected %h/%h/%h", ok, pc, opf8, opl8, e.pc, e.opf8, e.opl8);
        end
        jump = 1'b1;
        jump_target = 64'h2000;
        step();
        jump = 1'b0;
        checks++;
        if ({mem_addr, pc} !== {64'h2000, 64'h2000}) begin
            failures++;
            $display("FAIL jump_taken: addr=%h pc=%h, expected 2000 2000", mem_addr, pc);
        end
        step();
        checks++;
        if (mem_addr !== 64'h2008) begin
            failures++;
            $display("FAIL jump_fhi_addr: addr=%h, expected 2008", mem_addr);
        end
        jump = 1'b1;
        jump_target = 64'h5555_0000;
        step();
        jump = 1'b0;
        e = sb_q.size() == 0 ? expect_insn(64'h2000) : sb_q.pop_front();
        checks++;
        if (exec !== 1'b1 || {pc, opf8, opl8} !== e) begin
            failures++;
            $display("FAIL jump_target_insn: exec=%b got %h/%h/%h expected %h/%h/%h", exec, pc, opf8, opl8, e.pc, e.opf8, e.opl8);
        end
        step();
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 64'h200C}) begin
            failures++;
            $display("FAIL jump_ignored_outside_ex: req=%b addr=%h, expected 1 200c", mem_req, mem_addr);
        end
    endtask

    task automatic test_hold();
        int    n;
        bit    ok;
        insn_t e;
        sb_q.push_back(expect_insn(64'h200C));
        wait_exec(20, n, ok);
        e = sb_q.pop_front();
        checks++;
        if (!ok || {pc, opf8, opl8} !== e) begin
            failures++;
            $display("FAIL hold_insn: ok=%0d got %h/%h/%h expected %h/%h/%h", ok, pc, opf8, opl8, e.pc, e.opf8, e.opl8);
        end
        hold = 1'b1;
        jump = 1'b1;
        jump_target = 64'h7777_0000;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({exec, mem_req, pc, opf8, opl8} !== {1'b1, 1'b0, e}) begin
                failures++;
                $display("FAIL hold_stable[%0d]: exec=%b req=%b got %h/%h/%h expected %h/%h/%h",
                         i, exec, mem_req, pc, opf8, opl8, e.pc, e.opf8, e.opl8);
            end
        end
        hold = 1'b0;
        jump = 1'b0;
        wait_lo = 5;
        step();
        checks++;
        if ({exec, mem_req, mem_addr} !== {1'b0, 1'b1, 64'h2018}) begin
            failures++;
            $display("FAIL hold_release: exec=%b req=%b addr=%h, expected 0 1 2018", exec, mem_req, mem_addr);
        end
    endtask

    task automatic test_wait_states();
        int    n;
        int    waits;
        bit    ok;
        insn_t e;
        waits = 0;
        while (mem_ack !== 1'b1 && waits < 20) begin
            checks++;
            if ({mem_req, mem_addr, opf8} !== {1'b1, 64'h2018, mem_model(64'h200C)}) begin
                failures++;
                $display("FAIL wait_stable: req=%b addr=%h opf8=%h, expected 1 2018 %h",
                         mem_req, mem_addr, opf8, mem_model(64'h200C));
            end
            step();
            waits++;
        end
        wait_lo = 0;
        checks++;
        if (waits != 5) begin
            failures++;
            $display("FAIL wait_count: waited %0d cycles, expected 5", waits);
        end
        sb_q.push_back(expect_insn(64'h2018));
        wait_exec(20, n, ok);
        e = sb_q.pop_front();
        checks++;
        if (!ok || {pc, opf8, opl8} !== e) begin
            failures++;
            $display("FAIL wait_insn: ok=%0d got %h/%h/%h expected %h/%h/%h", ok, pc, opf8, opl8, e.pc, e.opf8, e.opl8);
        end
    endtask

    task automatic test_async_reset();
        int    n;
        bit    ok;
        insn_t e;
        step();
        step();
        checks++;
        if (mem_addr !== 64'h202C) begin
            failures++;
            $display("FAIL areset_in_fhi: addr=%h, expected 202c", mem_addr);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, exec, pc, opf8, opl8} !== {1'b0, 1'b0, RV, 64'h0, 64'h0}) begin
            failures++;
            $display("FAIL areset_immediate: req=%b exec=%b pc=%h opf8=%h opl8=%h, expected 0 0 %h 0 0",
                     mem_req, exec, pc, opf8, opl8, RV);
        end
        step();
        force_ack = 1'b1;
        step();
        rst_n = 1'b1;
        force_ack = 1'b0;
        step();
        checks++;
        if ({mem_req, mem_addr, opf8} !== {1'b1, RV, 64'h0}) begin
            failures++;
            $display("FAIL areset_late_ack: req=%b addr=%h opf8=%h, expected 1 %h 0", mem_req, mem_addr, opf8, RV);
        end
        sb_q.push_back(expect_insn(RV));
        wait_exec(20, n, ok);
        e = sb_q.pop_front();
        checks++;
        if (!ok || {pc, opf8, opl8} !== e) begin
            failures++;
            $display("FAIL areset_refetch: ok=%0d got %h/%h/%h expected %h/%h/%h", ok, pc, opf8, opl8, e.pc, e.opf8, e.opl8);
        end
    endtask

    task automatic test_wrap();
        int    n;
        bit    ok;
        insn_t e;
        jump = 1'b1;
        jump_target = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        jump = 1'b0;
        step();
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 64'h4}) begin
            failures++;
            $display("FAIL wrap_fhi_addr: req=%b addr=%h, expected 1 4", mem_req, mem_addr);
        end
        sb_q.push_back(expect_insn(64'hFFFF_FFFF_FFFF_FFFC));
        wait_exec(20, n, ok);
        e = sb_q.pop_front();
        checks++;
        if (!ok || {pc, opf8, opl8} !== e) begin
            failures++;
            $display("FAIL wrap_insn: ok=%0d got %h/%h/%h expected %h/%h/%h", ok, pc, opf8, opl8, e.pc, e.opf8, e.opl8);
        end
        step();
        checks++;
        if ({pc, mem_addr} !== {64'h8, 64'h8}) begin
            failures++;
            $display("FAIL wrap_next_pc: pc=%h addr=%h, expected 8 8", pc, mem_addr);
        end
    endtask

    task automatic test_back_to_back();
        int          n;
        bit          ok;
        insn_t       e;
        logic [63:0] exp_pc;
        exp_pc = 64'h8;
        for (int i = 0; i < 6; i++) begin
            sb_q.push_back(expect_insn(exp_pc));
            wait_exec(40, n, ok);
            e = sb_q.pop_front();
            checks++;
            if (!ok || {pc, opf8, opl8} !== e) begin
                failures++;
                $display("FAIL b2b_insn[%0d]: ok=%0d got %h/%h/%h expected %h/%h/%h",
                         i, ok, pc, opf8, opl8, e.pc, e.opf8, e.opl8);
            end
            jump = 1'($urandom_range(0, 1));
            jump_target = {$urandom, $urandom};
            wait_lo = int'($urandom_range(0, 2));
            wait_hi = int'($urandom_range(0, 2));
            exp_pc = jump ? jump_target : exp_pc + 64'd12;
            step();
            jump = 1'b0;
            checks++;
            if ({mem_req, mem_addr, pc} !== {1'b1, exp_pc, exp_pc}) begin
                failures++;
                $display("FAIL b2b_next[%0d]: req=%b addr=%h pc=%h, expected 1 %h %h",
                         i, mem_req, mem_addr, pc, exp_pc, exp_pc);
            end
        end
        wait_lo = 0;
        wait_hi = 0;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_jump();
        test_hold();
        test_wait_states();
        test_async_reset();
        test_wrap();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
